// File: rtl/cpu_io_stream_bridge.sv
// cpu_io_stream_bridge
// Bidirectional CPU <-> fabric lane bridge for the east IO tile.
// Operands flow CPU -> fabric through a DEPTH-entry FIFO with valid/ready.
// Results flow fabric -> CPU through a second DEPTH-entry FIFO. The fabric
// side has no backpressure, so a full result FIFO either drops the new word
// or overwrites the oldest one, and a sticky ovf flag records the loss.
module cpu_io_stream_bridge #(
  parameter int WIDTH        = 4,
  parameter int NUM_OPS      = 2,
  parameter int NUM_RES      = 3,
  parameter int DEPTH        = 4,
  parameter int NoConfigBits = 2
) (
  input  logic                       UserCLK,
  input  logic                       rst,
  input  logic [NoConfigBits-1:0]    ConfigBits,
  input  logic [NUM_OPS*WIDTH-1:0]   cpu_op_data,
  input  logic                       cpu_op_valid,
  output logic                       cpu_op_ready,
  output logic [NUM_OPS*WIDTH-1:0]   fab_op_data,
  output logic                       fab_op_valid,
  input  logic                       fab_op_ack,
  input  logic [NUM_RES*WIDTH-1:0]   fab_res_data,
  input  logic                       fab_res_we,
  output logic                       fab_res_full,
  output logic [NUM_RES*WIDTH-1:0]   cpu_res_data,
  output logic                       cpu_res_valid,
  input  logic                       cpu_res_ready,
  output logic                       ovf,
  input  logic                       ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = NUM_OPS * WIDTH;
  localparam int RW = NUM_RES * WIDTH;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic enable;
  logic overwrite;
  assign enable    = ConfigBits[0];
  assign overwrite = ConfigBits[1];

  // run_reg drops asynchronously with rst so ready falls immediately, but it
  // keeps rst itself out of the datapath logic.
  logic run_reg;

  // Run flag: low while in reset, high from the first edge after release.
  always_ff @(posedge UserCLK or posedge rst) begin
    if (rst) run_reg <= 1'b0;
    else     run_reg <= 1'b1;
  end

  // ---------------------------------------------------------------------
  // Operand FIFO (CPU -> fabric)
  // ---------------------------------------------------------------------
  logic [OW-1:0] op_mem [DEPTH];
  logic [AW-1:0] op_wr_ptr_reg;
  logic [AW-1:0] op_rd_ptr_reg;
  logic [AW:0]   op_count_reg;
  logic [OW-1:0] op_head;
  logic          op_push;
  logic          op_pop;

  assign cpu_op_ready = enable & run_reg & (op_count_reg != FULL_CNT);
  assign fab_op_valid = (op_count_reg != '0);
  assign op_push      = cpu_op_valid & cpu_op_ready;
  assign op_pop       = fab_op_ack & fab_op_valid;
  assign op_head      = op_mem[op_rd_ptr_reg];

  // Operand pointers and occupancy; disabling flushes to empty.
  always_ff @(posedge UserCLK or posedge rst) begin
    if (rst) begin
      op_wr_ptr_reg <= '0;
      op_rd_ptr_reg <= '0;
      op_count_reg  <= '0;
    end else if (!enable) begin
      op_wr_ptr_reg <= '0;
      op_rd_ptr_reg <= '0;
      op_count_reg  <= '0;
    end else begin
      if (op_push) op_wr_ptr_reg <= op_wr_ptr_reg + 1'b1;
      if (op_pop)  op_rd_ptr_reg <= op_rd_ptr_reg + 1'b1;
      op_count_reg <= op_count_reg + {{AW{1'b0}}, op_push} - {{AW{1'b0}}, op_pop};
    end
  end

  // Operand storage; contents need no reset since the count gates visibility.
  always_ff @(posedge UserCLK) begin
    if (op_push) op_mem[op_wr_ptr_reg] <= cpu_op_data;
  end

  // ---------------------------------------------------------------------
  // Result FIFO (fabric -> CPU)
  // ---------------------------------------------------------------------
  logic [RW-1:0] res_mem [DEPTH];
  logic [AW-1:0] res_wr_ptr_reg;
  logic [AW-1:0] res_rd_ptr_reg;
  logic [AW:0]   res_count_reg;
  logic [RW-1:0] res_head;
  logic          res_full;
  logic          res_we;
  logic          res_pop;
  logic          res_lost;      // write arrived while full with no pop
  logic          res_count_in;  // write that increases occupancy
  logic          res_write;     // write that lands in storage
  logic          res_rd_adv;

  assign res_full      = (res_count_reg == FULL_CNT);
  assign fab_res_full  = res_full;
  assign cpu_res_valid = (res_count_reg != '0);
  assign res_head      = res_mem[res_rd_ptr_reg];
  assign res_we        = fab_res_we & enable & run_reg;
  assign res_pop       = cpu_res_ready & cpu_res_valid;
  assign res_lost      = res_we & res_full & ~res_pop;
  assign res_count_in  = res_we & (~res_full | res_pop);
  // In overwrite mode a lost write still lands on the oldest slot, and the
  // read pointer steps past it so the FIFO keeps DEPTH newest words.
  assign res_write     = res_count_in | (res_lost & overwrite);
  assign res_rd_adv    = res_pop | (res_lost & overwrite);

  // Result pointers and occupancy; disabling flushes to empty.
  always_ff @(posedge UserCLK or posedge rst) begin
    if (rst) begin
      res_wr_ptr_reg <= '0;
      res_rd_ptr_reg <= '0;
      res_count_reg  <= '0;
    end else if (!enable) begin
      res_wr_ptr_reg <= '0;
      res_rd_ptr_reg <= '0;
      res_count_reg  <= '0;
    end else begin
      if (res_write)  res_wr_ptr_reg <= res_wr_ptr_reg + 1'b1;
      if (res_rd_adv) res_rd_ptr_reg <= res_rd_ptr_reg + 1'b1;
      res_count_reg <= res_count_reg + {{AW{1'b0}}, res_count_in} - {{AW{1'b0}}, res_pop};
    end
  end

  // Result storage.
  always_ff @(posedge UserCLK) begin
    if (res_write) res_mem[res_wr_ptr_reg] <= fab_res_data;
  end

  // Sticky overflow flag; a new loss beats a same-cycle clear.
  always_ff @(posedge UserCLK or posedge rst) begin
    if (rst)          ovf <= 1'b0;
    else if (res_lost) ovf <= 1'b1;
    else if (ovf_clr)  ovf <= 1'b0;
  end

  // ---------------------------------------------------------------------
  // Head outputs, forced to zero per lane while the FIFO is empty
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_op_lane
    assign fab_op_data[gi*WIDTH +: WIDTH] =
      fab_op_valid ? op_head[gi*WIDTH +: WIDTH] : '0;
  end

  for (genvar gi = 0; gi < NUM_RES; gi++) begin : g_res_lane
    assign cpu_res_data[gi*WIDTH +: WIDTH] =
      cpu_res_valid ? res_head[gi*WIDTH +: WIDTH] : '0;
  end

endmodule
